// File: rtl/noc_config_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : noc_config_pkg                                                |
// | Description : Shared configuration for the wormhole switch: default port    |
// |               count and flit width, plus the port-index type used for       |
// |               arbitration pointers and grant indices.                       |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
package noc_config_pkg;

   localparam int NUM_PORTS_DEF  = 5;
   localparam int FLIT_WIDTH_DEF = 64;

   // Port indices are carried at the width of the largest legal switch, so
   // one type serves every configuration; the top narrows it for grant_id.
   localparam int MAX_PORTS  = 16;
   localparam int PORT_IDX_W = $clog2(MAX_PORTS);

   typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage : noc_config_pkg
`default_nettype wire

// File: rtl/noc_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : noc_rr_arbiter                                                |
// | Description : Purely combinational round-robin selector. The search starts |
// |               at ptr_i+1 and wraps, so the last winner has lowest priority. |
// | Ports       : req_i     - request vector, one bit per input port            |
// |               ptr_i     - index of the previous winner                      |
// |               gnt_oh_o  - one-hot grant (all zero when no request)          |
// |               gnt_idx_o - binary index of the granted port                  |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module noc_rr_arbiter
   import noc_config_pkg::*;
#(
   parameter int NUM_PORTS = NUM_PORTS_DEF
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  port_idx_t            ptr_i,
   output logic [NUM_PORTS-1:0] gnt_oh_o,
   output port_idx_t            gnt_idx_o
);

   logic [NUM_PORTS-1:0] w_hi_mask;
   logic [NUM_PORTS-1:0] w_hi_req;
   logic [NUM_PORTS-1:0] w_pick;

   // Ports above the pointer form the high-priority half of the ring.
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_hi_mask
      assign w_hi_mask[g] = (port_idx_t'(g) > ptr_i);
   end

   assign w_hi_req = req_i & w_hi_mask;

   // If nobody above the pointer asks, the search wraps to port 0 upward.
   assign w_pick = (|w_hi_req) ? w_hi_req : req_i;

   // Lowest set bit of the chosen half wins; scanning downward lets the
   // lowest index overwrite any higher candidate.
   always_comb begin
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (w_pick[i]) begin
            gnt_oh_o    = '0;
            gnt_oh_o[i] = 1'b1;
            gnt_idx_o   = port_idx_t'(i);
         end
      end
   end

endmodule : noc_rr_arbiter
`default_nettype wire

// File: rtl/noc_wormhole_switch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : noc_wormhole_switch                                           |
// | Description : N-to-1 wormhole switch. A round-robin winner keeps the output |
// |               until its tail flit is accepted; flits pass through a small   |
// |               output FIFO (one cycle latency, registered output side).      |
// | Ports       : clk, rst            - clock, synchronous active-high reset    |
// |               in_valid/in_ready   - per-input handshake                     |
// |               in_flit/in_tail     - packed input flits and tail markers     |
// |               out_valid/out_ready - output handshake                        |
// |               out_flit/out_tail   - output flit and tail marker             |
// |               locked              - a packet is mid-transfer                |
// |               grant_id            - current or most recent granted input    |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module noc_wormhole_switch
   import noc_config_pkg::*;
#(
   parameter int                   NUM_PORTS       = NUM_PORTS_DEF,
   parameter int                   FLIT_WIDTH      = FLIT_WIDTH_DEF,
   parameter int                   FIFO_DEPTH      = 2,
   parameter logic [NUM_PORTS-1:0] AVAILABLE_PORTS = {NUM_PORTS{1'b1}}
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            in_valid,
   output logic [NUM_PORTS-1:0]            in_ready,
   input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [NUM_PORTS-1:0]            in_tail,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [FLIT_WIDTH-1:0]           out_flit,
   output logic                            out_tail,
   output logic                            locked,
   output logic [$clog2(NUM_PORTS)-1:0]    grant_id
);

   localparam int IDX_W = $clog2(NUM_PORTS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = FLIT_WIDTH + 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [0:0]       state_q,  state_d;
   port_idx_t        grant_q,  grant_d;
   port_idx_t        rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic [NUM_PORTS-1:0]  w_req;
   logic [NUM_PORTS-1:0]  w_arb_oh;
   port_idx_t             w_arb_idx;
   logic [NUM_PORTS-1:0]  w_lock_oh;
   logic [NUM_PORTS-1:0]  w_fire;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic [FLIT_WIDTH-1:0] w_push_flit;
   logic                  w_push_tail;
   port_idx_t             w_sel_idx;
   logic [ENT_W-1:0]      w_rd_ent;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      // Explicit wrap so non-power-of-two depths stay in range.
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Disabled inputs never enter arbitration, so their valids are ignored.
   assign w_req = in_valid & AVAILABLE_PORTS;

   noc_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS)
   ) u_arb (
      .req_i     (w_req),
      .ptr_i     (rr_ptr_q),
      .gnt_oh_o  (w_arb_oh),
      .gnt_idx_o (w_arb_idx)
   );

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lock_oh
      assign w_lock_oh[g] = (port_idx_t'(g) == grant_q);
   end

   assign w_full = (count_q == CNT_W'(FIFO_DEPTH));

   // Ready depends only on state, fill level and the arbiter; it never
   // sees the output side directly, so a full buffer refuses a push even
   // when a pop happens in the same cycle.
   always_comb begin
      in_ready = '0;
      if (!rst && !w_full) begin
         if (state_q == ST_IDLE) begin
            in_ready = w_arb_oh;
         end else begin
            in_ready = w_lock_oh & AVAILABLE_PORTS;
         end
      end
   end

   assign w_fire    = in_ready & in_valid;
   assign w_push    = |w_fire;
   assign w_sel_idx = (state_q == ST_IDLE) ? w_arb_idx : grant_q;

   // w_fire is at most one-hot, so a plain OR-mux picks the accepted flit.
   always_comb begin
      w_push_flit = '0;
      w_push_tail = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_fire[i]) begin
            w_push_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
            w_push_tail = in_tail[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Packet FSM and round-robin pointer
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      if (w_push) begin
         grant_d = w_sel_idx;
         if (w_push_tail) begin
            // Packet complete: release the output and rotate priority.
            state_d  = ST_IDLE;
            rr_ptr_d = w_sel_idx;
         end else begin
            state_d = ST_LOCKED;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO control
   // ------------------------------------------------------------------
   assign out_valid = (count_q != '0);
   assign w_pop     = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      unique case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         // Pointing at the last port makes port 0 the first candidate.
         rr_ptr_q <= port_idx_t'(NUM_PORTS - 1);
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; entries are only observed while counted.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {w_push_tail, w_push_flit};
      end
   end

   assign w_rd_ent = mem_q[rd_ptr_q];
   assign out_flit = w_rd_ent[FLIT_WIDTH-1:0];
   assign out_tail = w_rd_ent[FLIT_WIDTH];

   assign locked   = (state_q == ST_LOCKED);
   assign grant_id = IDX_W'(grant_q);

endmodule : noc_wormhole_switch
`default_nettype wire
